// File: rtl/wb_ram_slave.sv
// Wishbone single-beat RAM responder: programmable wait states, byte-lane write
// masking via SEL, and an address window outside of which transfers complete harmlessly.
module wb_ram_slave #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     DEPTH_WORDS = 1024,
  parameter int unsigned     WAIT_CYCLES = 1,
  parameter logic [XLEN-1:0] BASE_ADDR   = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   ADR,
  input  logic [XLEN/8-1:0] SEL,
  input  logic              WE,
  input  logic              STB,
  input  logic [XLEN-1:0]   DAT_W,
  output logic [XLEN-1:0]   DAT_R,
  output logic              ACK
);

  localparam int unsigned   LANES        = XLEN / 8;
  localparam int unsigned   LANE_W       = $clog2(LANES);
  localparam int unsigned   IDX_W        = $clog2(DEPTH_WORDS);
  localparam logic [XLEN:0] WINDOW_BYTES = (XLEN+1)'(DEPTH_WORDS * LANES);
  localparam logic [3:0]    WAIT_INIT    = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [XLEN-1:0]   adr_q, adr_d;
  logic [LANES-1:0]  sel_q, sel_d;
  logic              we_q, we_d;
  logic [XLEN-1:0]   dat_w_q, dat_w_d;
  logic [XLEN-1:0]   dat_r_q, dat_r_d;
  logic              ack_q, ack_d;

  logic [XLEN-1:0]   mem [DEPTH_WORDS];

  // With zero wait states the commit happens on the same edge that captures the
  // request, so the live bus is used in IDLE and the captured copy afterwards.
  logic [XLEN-1:0]   req_adr;
  logic [LANES-1:0]  req_sel;
  logic              req_we;
  logic [XLEN-1:0]   req_dat;
  logic [XLEN:0]     req_off;
  logic              req_in_range;
  logic [IDX_W-1:0]  req_idx;
  logic [XLEN-1:0]   mem_rd;
  logic              commit;
  logic              mem_we;

  always_comb begin
    req_adr      = (state_q == ST_IDLE) ? ADR   : adr_q;
    req_sel      = (state_q == ST_IDLE) ? SEL   : sel_q;
    req_we       = (state_q == ST_IDLE) ? WE    : we_q;
    req_dat      = (state_q == ST_IDLE) ? DAT_W : dat_w_q;
    req_off      = {1'b0, req_adr} - {1'b0, BASE_ADDR};
    req_in_range = (req_adr >= BASE_ADDR) && (req_off < WINDOW_BYTES);
    req_idx      = req_off[LANE_W +: IDX_W];
    mem_rd       = mem[req_idx];
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    sel_d   = sel_q;
    we_d    = we_q;
    dat_w_d = dat_w_q;
    dat_r_d = dat_r_q;
    ack_d   = 1'b0;
    commit  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (STB) begin
          adr_d   = ADR;
          sel_d   = SEL;
          we_d    = WE;
          dat_w_d = DAT_W;
          if (WAIT_INIT == 4'd0) begin
            state_d = ST_RESP;
            commit  = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        // Master withdrawing STB before completion abandons the transfer.
        if (!STB) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q <= 4'd1) begin
          state_d = ST_RESP;
          cnt_d   = 4'd0;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    if (commit) begin
      ack_d = 1'b1;
      if (!req_we) begin
        dat_r_d = req_in_range ? mem_rd : '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      adr_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      dat_w_q <= '0;
      dat_r_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      dat_w_q <= dat_w_d;
      dat_r_q <= dat_r_d;
      ack_q   <= ack_d;
    end
  end

  // Gating with rst_n keeps a request sitting on the bus during reset from landing.
  assign mem_we = commit && req_we && req_in_range && rst_n;

  // NOTE: the storage array has no reset; only control state is cleared, which
  // lets the array map onto plain RAM macros.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (req_sel[i]) begin
          mem[req_idx][i*8 +: 8] <= req_dat[i*8 +: 8];
        end
      end
    end
  end

  assign DAT_R = dat_r_q;
  assign ACK   = ack_q;

  a_ack_single_cycle: assert property (@(posedge clk) disable iff (!rst_n) ack_q |=> !ack_q);

endmodule

// File: tb/tb_wb_ram_slave.sv
// Bench for wb_ram_slave: three instances (1, 0 and 3 wait states, one offset base)
// checked against a word-array reference model with per-lane write masking.
module tb_wb_ram_slave;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] adr_s [3];
  logic [3:0]  sel_s [3];
  logic        we_s  [3];
  logic        stb_s [3];
  logic [31:0] dw_s  [3];
  logic [31:0] dr_s  [3];
  logic        ack_s [3];

  logic [31:0] model   [3][DEPTH];
  logic [31:0] last_rd [3];
  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wb_ram_slave #(.XLEN(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1), .BASE_ADDR(32'h0)) u_w1 (
    .clk(clk), .rst_n(rst_n), .ADR(adr_s[0]), .SEL(sel_s[0]), .WE(we_s[0]), .STB(stb_s[0]),
    .DAT_W(dw_s[0]), .DAT_R(dr_s[0]), .ACK(ack_s[0]));
  wb_ram_slave #(.XLEN(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_w0 (
    .clk(clk), .rst_n(rst_n), .ADR(adr_s[1]), .SEL(sel_s[1]), .WE(we_s[1]), .STB(stb_s[1]),
    .DAT_W(dw_s[1]), .DAT_R(dr_s[1]), .ACK(ack_s[1]));
  wb_ram_slave #(.XLEN(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3), .BASE_ADDR(32'h1000)) u_w3 (
    .clk(clk), .rst_n(rst_n), .ADR(adr_s[2]), .SEL(sel_s[2]), .WE(we_s[2]), .STB(stb_s[2]),
    .DAT_W(dw_s[2]), .DAT_R(dr_s[2]), .ACK(ack_s[2]));

  function automatic int wait_of(input int d);
    case (d)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  function automatic logic [31:0] base_of(input int d);
    return (d == 2) ? 32'h1000 : 32'h0;
  endfunction

  function automatic bit in_win(input int d, input logic [31:0] a);
    longint ua;
    longint ub;
    ua = a;
    ub = base_of(d);
    return (ua >= ub) && ((ua - ub) < longint'(DEPTH * 4));
  endfunction

  function automatic int win_idx(input int d, input logic [31:0] a);
    longint ua;
    longint ub;
    ua = a;
    ub = base_of(d);
    return int'((ua - ub) / 4);
  endfunction

  function automatic logic [31:0] model_read(input int d, input logic [31:0] a);
    if (!in_win(d, a)) return 32'h0;
    return model[d][win_idx(d, a)];
  endfunction

  task automatic model_write(input int d, input logic [31:0] a, input logic [3:0] sel,
                             input logic [31:0] wd);
    logic [31:0] w;
    if (in_win(d, a)) begin
      w = model[d][win_idx(d, a)];
      for (int i = 0; i < 4; i++) if (sel[i]) w[i*8 +: 8] = wd[i*8 +: 8];
      model[d][win_idx(d, a)] = w;
    end
  endtask

  // Called just after a rising edge; returns just after the edge that ends the ACK cycle.
  task automatic txn(input int d, input bit we, input logic [31:0] a, input logic [3:0] sel,
                     input logic [31:0] wd, input string tag);
    logic [31:0] exp_rd;
    int          exp_lat;
    bit          seen;
    exp_lat = 1 + wait_of(d);
    exp_rd  = we ? last_rd[d] : model_read(d, a);
    adr_s[d] = a; sel_s[d] = sel; we_s[d] = we; dw_s[d] = wd; stb_s[d] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (ack_s[d]) begin
        seen = 1'b1;
        n_cmp++;
        if (k !== exp_lat) begin
          n_fail++;
          $display("FAIL %s latency: got %0d cycles, expected %0d", tag, k, exp_lat);
        end
        n_cmp++;
        if (dr_s[d] !== exp_rd) begin
          n_fail++;
          $display("FAIL %s dat_r: got %h, expected %h", tag, dr_s[d], exp_rd);
        end
      end
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s timeout: no ACK within 40 cycles, expected after %0d", tag, exp_lat);
    end
    @(posedge clk);
    #1;
    stb_s[d] = 1'b0;
    if (seen) begin
      if (we) model_write(d, a, sel, wd);
      else    last_rd[d] = exp_rd;
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (ack_s[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_ack[%0d]: got %b, expected 0", d, ack_s[d]);
      end
      n_cmp++;
      if (dr_s[d] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_dat_r[%0d]: got %h, expected 0", d, dr_s[d]);
      end
    end
  endtask

  task automatic preload();
    for (int d = 0; d < 3; d++)
      for (int w = 0; w < DEPTH; w++)
        txn(d, 1'b1, base_of(d) + 32'(w * 4), 4'hF, $urandom, "preload");
  endtask

  task automatic test_basic_rw();
    txn(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, "t1_write");
    txn(0, 1'b0, 32'h10, 4'hF, 32'h0, "t1_read");
    n_cmp++;
    if (dr_s[0] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL t1_value: got %h, expected deadbeef", dr_s[0]);
    end
  endtask

  task automatic test_byte_lanes();
    txn(0, 1'b1, 32'h20, 4'hF, 32'h11223344, "t2_full");
    txn(0, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, "t2_mask");
    txn(0, 1'b1, 32'h20, 4'b0000, 32'hFFFFFFFF, "t2_sel0");
    txn(0, 1'b0, 32'h22, 4'h0, 32'h0, "t2_read");
    n_cmp++;
    if (dr_s[0] !== 32'h11BB33DD) begin
      n_fail++;
      $display("FAIL t2_value: got %h, expected 11bb33dd", dr_s[0]);
    end
  endtask

  task automatic test_back_to_back();
    int acks;
    int k;
    acks = 0;
    k = 0;
    adr_s[1] = 32'h0; sel_s[1] = 4'h0; we_s[1] = 1'b0; dw_s[1] = 32'h0; stb_s[1] = 1'b1;
    while (acks < 4 && k < 20) begin
      @(negedge clk);
      if (ack_s[1]) begin
        n_cmp++;
        if (k !== 2 * acks + 1) begin
          n_fail++;
          $display("FAIL t3_ack_cycle[%0d]: got cycle %0d, expected %0d", acks, k, 2 * acks + 1);
        end
        n_cmp++;
        if (dr_s[1] !== model[1][acks]) begin
          n_fail++;
          $display("FAIL t3_data[%0d]: got %h, expected %h", acks, dr_s[1], model[1][acks]);
        end
        last_rd[1] = model[1][acks];
        acks++;
      end
      @(posedge clk);
      #1;
      adr_s[1] = 32'(acks * 4);
      k++;
    end
    stb_s[1] = 1'b0;
    n_cmp++;
    if (acks !== 4) begin
      n_fail++;
      $display("FAIL t3_ack_count: got %0d, expected 4", acks);
    end
  endtask

  task automatic test_out_of_range();
    txn(0, 1'b0, 32'h100, 4'hF, 32'h0, "t4_read_oor");
    n_cmp++;
    if (dr_s[0] !== 32'h0) begin
      n_fail++;
      $display("FAIL t4_oor_value: got %h, expected 0", dr_s[0]);
    end
    txn(0, 1'b1, 32'h100, 4'hF, 32'h12345678, "t4_write_oor");
    txn(0, 1'b0, 32'h0, 4'hF, 32'h0, "t4_read_word0");
    txn(0, 1'b0, 32'hFF, 4'hF, 32'h0, "t4_read_last");
    txn(2, 1'b0, 32'hFFC, 4'hF, 32'h0, "t4_below_base");
    txn(2, 1'b0, 32'h10FF, 4'hF, 32'h0, "t4_top_of_window");
    txn(2, 1'b0, 32'h1100, 4'hF, 32'h0, "t4_above_window");
    txn(2, 1'b0, 32'hFFFF_FFFC, 4'hF, 32'h0, "t4_addr_max");
  endtask

  task automatic test_abort();
    int stray;
    logic [31:0] a;
    stray = 0;
    a = 32'h101C;
    adr_s[2] = a; sel_s[2] = 4'hF; we_s[2] = 1'b1; dw_s[2] = ~model_read(2, a); stb_s[2] = 1'b1;
    @(posedge clk);
    #1;
    stb_s[2] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ack_s[2]) stray++;
    end
    n_cmp++;
    if (stray !== 0) begin
      n_fail++;
      $display("FAIL t5_abort_ack: got %0d ACK cycles, expected 0", stray);
    end
    @(posedge clk);
    #1;
    txn(2, 1'b0, a, 4'hF, 32'h0, "t5_read_back");
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] a;
    a = 32'h1014;
    txn(2, 1'b1, a, 4'hF, 32'hC0FFEE01, "t6_seed");
    txn(2, 1'b0, a, 4'hF, 32'h0, "t6_pre_read");
    adr_s[2] = a; sel_s[2] = 4'hF; we_s[2] = 1'b1; dw_s[2] = 32'h5A5A5A5A; stb_s[2] = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    stb_s[2] = 1'b0;
    #1;
    n_cmp++;
    if (dr_s[2] !== 32'h0) begin
      n_fail++;
      $display("FAIL t6_dat_r_cleared: got %h, expected 0", dr_s[2]);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (ack_s[2] !== 1'b0) begin
        n_fail++;
        $display("FAIL t6_ack_in_reset: got %b, expected 0", ack_s[2]);
      end
    end
    rst_n = 1'b1;
    for (int d = 0; d < 3; d++) last_rd[d] = 32'h0;
    @(posedge clk);
    #1;
    txn(2, 1'b0, a, 4'hF, 32'h0, "t6_post_read");
  endtask

  task automatic test_random();
    logic [31:0] a;
    int          mode;
    for (int n = 0; n < 120; n++) begin
      int d;
      d = n % 3;
      mode = int'($urandom_range(0, 9));
      if (mode < 8)
        a = base_of(d) + $urandom_range(0, DEPTH * 4 - 1);
      else if (mode == 8 || base_of(d) == 32'h0)
        a = base_of(d) + 32'(DEPTH * 4) + $urandom_range(0, 1023);
      else
        a = base_of(d) - 32'($urandom_range(1, 64));
      txn(d, 1'($urandom_range(0, 1)), a, 4'($urandom), $urandom, "rand");
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      adr_s[d] = '0; sel_s[d] = '0; we_s[d] = 1'b0; stb_s[d] = 1'b0; dw_s[d] = '0;
      last_rd[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    preload();
    test_basic_rw();
    test_byte_lanes();
    test_back_to_back();
    test_out_of_range();
    test_abort();
    test_reset_mid_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
